omi_phy_lane_model: RTL and testbench

Parametrised behavioural PHY channel model for host<->device OMI simulation tops. It replaces hard-wired lane loopback (rx_valid=1, rx_slip ignored, zero skew) with a registered N-lane channel per direction. The channel adds per-lane programmable skew, a 66-bit block-slip alignment model driven by the receiving DLx's rx_slip, link-down emulation, and optional bit-error injection. Two instances per top, one per direction, sit between dlx_lN_tx_* and lnN_rx_*.

---
 rtl/omi_phy_lane_model.sv | 140 ++++++++++++++
 tb/tb_omi_phy_lane_model.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/omi_phy_lane_model.sv
// Registered N-lane OMI PHY channel: per-lane skew, 66-bit block slip, link-down emulation.
// Optional bit-error injection is built only when OMI_PHY_ERR_INJ_EN is defined.
module omi_phy_lane_model #(
   parameter int LANES   = 8,
   parameter int DATA_W  = 64,
   parameter int MAX_DLY = 8,
   parameter int DLY_W   = 4
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    link_en,
   input  logic [2*LANES-1:0]      tx_header,
   input  logic [DATA_W*LANES-1:0] tx_data,
   input  logic [DLY_W*LANES-1:0]  cfg_dly,
   input  logic [LANES-1:0]        rx_slip,
   output logic [LANES-1:0]        rx_valid,
   output logic [2*LANES-1:0]      rx_header,
   output logic [DATA_W*LANES-1:0] rx_data,
   input  logic                    inj_stb,
   input  logic [2:0]              inj_lane,
   input  logic [6:0]              inj_bit,
   output logic                    inj_done
);
   localparam int BW    = DATA_W + 2;
   localparam int OFF_W = $clog2(BW);
   localparam int CNT_W = $clog2(MAX_DLY + 2);

   typedef logic [BW-1:0] blk_t;

   blk_t             sr      [LANES][MAX_DLY];  // sr[i][k]: block entered k+1 cycles ago
   logic [OFF_W-1:0] off     [LANES];
   logic [CNT_W-1:0] fill_cnt;
   blk_t             blk_in  [LANES];
   blk_t             cur_b   [LANES];
   blk_t             prev_b  [LANES];
   logic [2*BW-1:0]  win     [LANES];
   blk_t             aligned [LANES];
   blk_t             out_blk [LANES];

   function automatic int unsigned tap(input logic [DLY_W-1:0] c);
      int unsigned v;
      v = 32'(c);
      return (v > 32'(MAX_DLY - 1)) ? 32'(MAX_DLY - 1) : v;
   endfunction

   always_comb begin
      for (int unsigned i = 0; i < LANES; i++) begin
         blk_in[i] = {tx_header[2*i +: 2], tx_data[DATA_W*i +: DATA_W]};
         cur_b[i]  = blk_in[i];
         prev_b[i] = sr[i][0];
         for (int unsigned k = 1; k < MAX_DLY; k++) begin
            if (tap(cfg_dly[DLY_W*i +: DLY_W]) == k) begin
               cur_b[i]  = sr[i][k-1];
               prev_b[i] = sr[i][k];
            end
         end
         win[i]     = {cur_b[i], prev_b[i]};
         aligned[i] = win[i][off[i] +: BW];
      end
   end

`ifdef OMI_PHY_ERR_INJ_EN
   logic       inj_pend;
   logic [2:0] pend_lane;
   logic [6:0] pend_bit;
   logic       inj_accept;
   blk_t       inj_mask [LANES];

   // A strobe is captured as pending, then applied to the following registered block.
   assign inj_accept = inj_stb && !inj_pend && (32'(inj_lane) < LANES) &&
                       (32'(inj_bit) < BW) && rx_valid[inj_lane];

   always_comb begin
      for (int unsigned i = 0; i < LANES; i++) begin
         inj_mask[i] = '0;
         if (inj_pend && (32'(pend_lane) == i))
            inj_mask[i][pend_bit] = 1'b1;
         out_blk[i] = aligned[i] ^ inj_mask[i];
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         inj_pend  <= 1'b0;
         pend_lane <= '0;
         pend_bit  <= '0;
         inj_done  <= 1'b0;
      end else begin
         inj_done <= inj_pend && link_en;
         if (inj_pend) begin
            inj_pend <= 1'b0;
         end else if (inj_accept) begin
            inj_pend  <= 1'b1;
            pend_lane <= inj_lane;
            pend_bit  <= inj_bit;
         end
      end
   end
`else
   logic unused_inj;
   assign unused_inj = ^{inj_stb, inj_lane, inj_bit};
   assign inj_done   = 1'b0;

   always_comb begin
      for (int unsigned i = 0; i < LANES; i++)
         out_blk[i] = aligned[i];
   end
`endif

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int unsigned i = 0; i < LANES; i++) begin
            for (int unsigned k = 0; k < MAX_DLY; k++)
               sr[i][k] <= '0;
            off[i] <= '0;
         end
         fill_cnt  <= '0;
         rx_valid  <= '0;
         rx_header <= '0;
         rx_data   <= '0;
      end else begin
         for (int unsigned i = 0; i < LANES; i++) begin
            sr[i][0] <= blk_in[i];
            for (int unsigned k = 1; k < MAX_DLY; k++)
               sr[i][k] <= sr[i][k-1];
            if (rx_slip[i])
               off[i] <= (off[i] == OFF_W'(BW - 1)) ? '0 : off[i] + 1'b1;
            if (link_en)
               {rx_header[2*i +: 2], rx_data[DATA_W*i +: DATA_W]} <= out_blk[i];
            else
               {rx_header[2*i +: 2], rx_data[DATA_W*i +: DATA_W]} <= '0;
         end
         if (!link_en)
            fill_cnt <= '0;
         else if (fill_cnt != CNT_W'(MAX_DLY + 1))
            fill_cnt <= fill_cnt + 1'b1;
         rx_valid <= (link_en && (fill_cnt >= CNT_W'(MAX_DLY))) ? '1 : '0;
      end
   end
endmodule

// File: tb/tb_omi_phy_lane_model.sv
// Bench for omi_phy_lane_model: constant-pattern table, directed sequences, randomized
// traffic against a history-based channel model. Injection checks follow OMI_PHY_ERR_INJ_EN.
module tb_omi_phy_lane_model;
   localparam int LANES   = 8;
   localparam int DW      = 64;
   localparam int BW      = DW + 2;
   localparam int MAX_DLY = 8;

   logic                clk = 1'b0;
   logic                rst = 1'b1;
   logic                link_en = 1'b1;
   logic [2*LANES-1:0]  tx_header = '0;
   logic [DW*LANES-1:0] tx_data = '0;
   logic [4*LANES-1:0]  cfg_dly = '0;
   logic [LANES-1:0]    rx_slip = '0;
   logic [LANES-1:0]    rx_valid;
   logic [2*LANES-1:0]  rx_header;
   logic [DW*LANES-1:0] rx_data;
   logic                inj_stb = 1'b0;
   logic [2:0]          inj_lane = '0;
   logic [6:0]          inj_bit = '0;
   logic                inj_done;

   omi_phy_lane_model #(.LANES(LANES), .DATA_W(DW), .MAX_DLY(MAX_DLY), .DLY_W(4)) dut (
      .clk(clk), .rst(rst), .link_en(link_en), .tx_header(tx_header), .tx_data(tx_data),
      .cfg_dly(cfg_dly), .rx_slip(rx_slip), .rx_valid(rx_valid), .rx_header(rx_header),
      .rx_data(rx_data), .inj_stb(inj_stb), .inj_lane(inj_lane), .inj_bit(inj_bit),
      .inj_done(inj_done)
   );

   always #5 clk = ~clk;

   int n_vec = 0;
   int n_mis = 0;

   // Channel model: full block history per lane, slip offsets, consecutive link-up count.
   logic [BW-1:0] hist [LANES][MAX_DLY+1];
   int unsigned   off_m [LANES];
   int unsigned   run;
   logic          exp_valid;
   logic          pend;
   int unsigned   pl, pb;

   task automatic model_clear();
      for (int l = 0; l < LANES; l++) begin
         for (int j = 0; j <= MAX_DLY; j++) hist[l][j] = '0;
         off_m[l] = 0;
      end
      run = 0;
      exp_valid = 1'b0;
      pend = 1'b0;
   endtask

   task automatic check(input string tag, input logic ok, input string act, input string req);
      n_vec++;
      if (!ok) begin
         n_mis++;
         $display("FAIL %s: got %s want %s", tag, act, req);
      end
   endtask

   task automatic step(input string tag);
      logic [BW-1:0]       blk [LANES];
      logic [2*BW-1:0]     w;
      logic [2*LANES-1:0]  e_hdr;
      logic [DW*LANES-1:0] e_dat;
      logic                e_done;
      int unsigned         c, d;
      logic                ok;
      @(posedge clk);
      #1;
      for (int l = 0; l < LANES; l++) begin
         for (int j = MAX_DLY; j >= 1; j--) hist[l][j] = hist[l][j-1];
         hist[l][0] = {tx_header[2*l +: 2], tx_data[DW*l +: DW]};
      end
      run = link_en ? run + 1 : 0;
      for (int l = 0; l < LANES; l++) begin
         c = 32'(cfg_dly[4*l +: 4]);
         d = (c > MAX_DLY - 1) ? MAX_DLY - 1 : c;
         w = {hist[l][d], hist[l][d+1]} >> off_m[l];
         blk[l] = link_en ? w[BW-1:0] : '0;
         if (rx_slip[l]) off_m[l] = (off_m[l] + 1) % BW;
      end
      e_done = 1'b0;
`ifdef OMI_PHY_ERR_INJ_EN
      if (pend) begin
         if (link_en) begin
            blk[pl][pb] = ~blk[pl][pb];
            e_done = 1'b1;
         end
         pend = 1'b0;
      end else if (inj_stb && exp_valid && (32'(inj_lane) < LANES) && (32'(inj_bit) < BW)) begin
         pend = 1'b1;
         pl = 32'(inj_lane);
         pb = 32'(inj_bit);
      end
`endif
      exp_valid = link_en && (run >= MAX_DLY + 1);
      for (int l = 0; l < LANES; l++) begin
         e_hdr[2*l +: 2]  = blk[l][BW-1 -: 2];
         e_dat[DW*l +: DW] = blk[l][DW-1:0];
      end
      ok = (rx_valid === {LANES{exp_valid}}) && (rx_header === e_hdr) &&
           (rx_data === e_dat) && (inj_done === e_done);
      check(tag, ok,
            $sformatf("v=%h h=%h done=%b d=%h", rx_valid, rx_header, inj_done, rx_data),
            $sformatf("v=%h h=%h done=%b d=%h", {LANES{exp_valid}}, e_hdr, e_done, e_dat));
   endtask

   task automatic do_reset(input string tag);
      rst = 1'b0;
      #1;
      check(tag, (rx_valid === '0) && (rx_header === '0) && (rx_data === '0) && (inj_done === 1'b0),
            $sformatf("v=%h h=%h done=%b", rx_valid, rx_header, inj_done), "all zero");
      model_clear();
      repeat (2) @(posedge clk);
      #3;
      rst = 1'b1;
   endtask

   task automatic set_pattern();
      logic [63:0] p;
      for (int l = 0; l < LANES; l++) begin
         p = 64'(l) * 64'h0101010101010101;
         tx_data[DW*l +: DW] = p;
         tx_header[2*l +: 2] = 2'b01;
      end
   endtask

   typedef struct {
      logic link;
      logic exp_valid;
      logic exp_pat;
   } vec_t;

   vec_t tbl [24];

   initial begin
      logic [63:0]         p;
      logic [2*LANES-1:0]  ph;
      logic [DW*LANES-1:0] pd;
      logic                ok;
      int                  n;
      logic [63:0]         inc;
      int unsigned         link_hold;

      n = 0;
      tbl[n++] = '{1'b1, 1'b0, 1'b0};
      for (int i = 0; i < 7; i++) tbl[n++] = '{1'b1, 1'b0, 1'b1};
      for (int i = 0; i < 2; i++) tbl[n++] = '{1'b1, 1'b1, 1'b1};
      for (int i = 0; i < 4; i++) tbl[n++] = '{1'b0, 1'b0, 1'b0};
      for (int i = 0; i < 8; i++) tbl[n++] = '{1'b1, 1'b0, 1'b1};
      for (int i = 0; i < 2; i++) tbl[n++] = '{1'b1, 1'b1, 1'b1};

      model_clear();
      set_pattern();
      for (int l = 0; l < LANES; l++) begin
         p = 64'(l) * 64'h0101010101010101;
         pd[DW*l +: DW] = p;
         ph[2*l +: 2] = 2'b01;
      end
      #2;
      do_reset("reset_initial");

      // Constant pattern: fill timing, link drop and refill.
      for (int i = 0; i < 24; i++) begin
         link_en = tbl[i].link;
         step($sformatf("tbl_model_%0d", i));
         ok = (rx_valid === {LANES{tbl[i].exp_valid}}) &&
              (rx_header === (tbl[i].exp_pat ? ph : '0)) &&
              (rx_data === (tbl[i].exp_pat ? pd : '0));
         check($sformatf("tbl_%0d", i), ok,
               $sformatf("v=%h h=%h", rx_valid, rx_header),
               $sformatf("v=%h pat=%b", {LANES{tbl[i].exp_valid}}, tbl[i].exp_pat));
      end

      // Injection on lane 2, header MSB.
      inj_stb = 1'b1; inj_lane = 3'd2; inj_bit = 7'd65;
      step("inj_accept");
      inj_stb = 1'b0;
      step("inj_apply");
`ifdef OMI_PHY_ERR_INJ_EN
      check("inj_flip", (rx_header[5:4] === 2'b11) && (inj_done === 1'b1),
            $sformatf("h2=%b done=%b", rx_header[5:4], inj_done), "h2=11 done=1");
`else
      check("inj_ignored", (rx_header[5:4] === 2'b01) && (inj_done === 1'b0),
            $sformatf("h2=%b done=%b", rx_header[5:4], inj_done), "h2=01 done=0");
`endif
      step("inj_after");
      check("inj_one_cycle", (rx_header[5:4] === 2'b01) && (inj_done === 1'b0),
            $sformatf("h2=%b done=%b", rx_header[5:4], inj_done), "h2=01 done=0");
      inj_stb = 1'b1; inj_bit = 7'd66;
      step("inj_bad_bit_a");
      inj_stb = 1'b0;
      step("inj_bad_bit_b");
      check("inj_bad_bit", inj_done === 1'b0, $sformatf("done=%b", inj_done), "done=0");
      link_en = 1'b0;
      step("inj_link_down");
      link_en = 1'b1; inj_stb = 1'b1; inj_bit = 7'd3;
      step("inj_invalid_a");
      inj_stb = 1'b0;
      step("inj_invalid_b");
      check("inj_invalid", inj_done === 1'b0, $sformatf("done=%b", inj_done), "done=0");
      repeat (9) step("refill");

      // Incrementing data, skewed lane 3, then out-of-range skew.
      inc = 64'h100;
      cfg_dly[4*3 +: 4] = 4'd5;
      for (int t = 0; t < 30; t++) begin
         for (int l = 0; l < LANES; l++) tx_data[DW*l +: DW] = inc;
         inc++;
         if (t == 15) cfg_dly[4*3 +: 4] = 4'd12;
         step($sformatf("skew_%0d", t));
      end
      cfg_dly = '0;

      // Single slip pulse on lane 0, then hold to complete 66 slips.
      rx_slip[0] = 1'b1;
      step("slip_pulse");
      rx_slip[0] = 1'b0;
      for (int t = 0; t < 3; t++) begin
         for (int l = 0; l < LANES; l++) tx_data[DW*l +: DW] = {$urandom, $urandom};
         step($sformatf("slip1_%0d", t));
      end
      rx_slip[0] = 1'b1;
      for (int t = 0; t < 65; t++) step($sformatf("slip_hold_%0d", t));
      rx_slip[0] = 1'b0;
      for (int t = 0; t < 4; t++) begin
         for (int l = 0; l < LANES; l++) tx_data[DW*l +: DW] = {$urandom, $urandom};
         step($sformatf("slip_wrap_%0d", t));
      end

      // Randomized traffic.
      link_hold = 0;
      for (int t = 0; t < 500; t++) begin
         for (int l = 0; l < LANES; l++) begin
            tx_data[DW*l +: DW] = {$urandom, $urandom};
            tx_header[2*l +: 2] = 2'($urandom);
            rx_slip[l] = ($urandom_range(0, 7) == 0);
         end
         if ($urandom_range(0, 15) == 0) cfg_dly[4*$urandom_range(0, 7) +: 4] = 4'($urandom);
         if (link_hold != 0) begin
            link_hold--;
            link_en = (link_hold == 0);
         end else if ($urandom_range(0, 63) == 0) begin
            link_en = 1'b0;
            link_hold = $urandom_range(1, 5);
         end
         inj_stb  = ($urandom_range(0, 3) == 0);
         inj_lane = 3'($urandom);
         inj_bit  = 7'($urandom_range(0, 70));
         step($sformatf("rand_%0d", t));
         if (t == 300) do_reset("reset_mid");
      end
      rx_slip = '0; inj_stb = 1'b0; link_en = 1'b1;
      repeat (12) step("tail");

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: got no finish want finish");
      $fatal(1);
   end
endmodule
